// File: rtl/toggle_event_rx_pkg.sv
// Shared types and default parameters for the
// toggle-encoded event receiver.
package toggle_event_rx_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_PEND_DEPTH  = 8;
    localparam int DEF_CNT_W       = 8;

    // Width of the pending-event counter
    localparam int PEND_W = 4;

    // Warm-up counter must reach SYNC_STAGES (max 4)
    localparam int WARM_W = 3;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } rx_state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-stage flop chain for bringing an asynchronous
// level into the clk domain.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw input through the chain, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receives toggle-encoded events from an async T latch,
// queues them as a pending count with a valid/ready drain.
module toggle_event_rx
    import toggle_event_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int PEND_DEPTH  = DEF_PEND_DEPTH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              t_in,
    input  logic              evt_ready,
    input  logic              ovf_clr,
    output logic              evt_pulse,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  event_count,
    output logic              overflow
);

    logic              w_sync;
    logic              w_hs;
    logic              w_full;
    logic              w_drop;

    rx_state_e         r_state;
    logic [WARM_W-1:0] r_wcnt;
    logic              r_ref;
    logic              r_pulse;
    logic [PEND_W-1:0] r_pending;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (t_in),
        .q     (w_sync)
    );

    assign w_hs   = evt_valid && evt_ready;
    assign w_full = (r_pending == PEND_W'(PEND_DEPTH));
    assign w_drop = r_pulse && w_full && !w_hs;

    // Warm up until the chain holds a real sample, then
    // flag every change of the synchronized level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WARMUP;
            r_wcnt  <= '0;
            r_ref   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    r_pulse <= 1'b0;
                    if (r_wcnt == WARM_W'(SYNC_STAGES)) begin
                        r_state <= ST_RUN;
                        r_ref   <= w_sync;
                    end else begin
                        r_wcnt <= r_wcnt + WARM_W'(1);
                    end
                end
                ST_RUN: begin
                    r_pulse <= (w_sync != r_ref);
                    r_ref   <= w_sync;
                end
                default: begin
                    r_state <= ST_WARMUP;
                    r_pulse <= 1'b0;
                end
            endcase
        end
    end

    // Pending count: add on pulse, remove on handshake,
    // hold when both happen or when a full queue drops
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else if (r_pulse && !w_hs && !w_full) begin
            r_pending <= r_pending + PEND_W'(1);
        end else if (!r_pulse && w_hs) begin
            r_pending <= r_pending - PEND_W'(1);
        end
    end

    // Count every detected toggle, dropped ones included
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_pulse) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Sticky overflow; a fresh drop beats a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign evt_pulse   = r_pulse;
    assign evt_valid   = (r_pending != '0);
    assign pending     = r_pending;
    assign event_count = r_count;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Self-checking bench for toggle_event_rx: pulse timing
// scoreboard plus table and hand sequences for the queue.
module tb_toggle_event_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       t_in;
    logic       evt_ready;
    logic       ovf_clr;
    logic       evt_pulse;
    logic       evt_valid;
    logic [3:0] pending;
    logic [7:0] event_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];

    typedef struct {
        int gap;
        bit ready;
        int exp_pend;
        int exp_cnt;
        bit exp_ovf;
    } vec_t;

    vec_t vt[10];

    toggle_event_rx dut (
        .clk         (clk),
        .reset       (reset),
        .t_in        (t_in),
        .evt_ready   (evt_ready),
        .ovf_clr     (ovf_clr),
        .evt_pulse   (evt_pulse),
        .evt_valid   (evt_valid),
        .pending     (pending),
        .event_count (event_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act,
                       input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Flip the T-latch level; pulse is due 3 edges later
    task automatic toggle();
        t_in = ~t_in;
        exp_q.push_back(cyc + 3);
    endtask

    // Pulse monitor: every pulse must match a due toggle
    int mon_e;
    always @(posedge clk) begin
        #1;
        if (evt_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_cycle", cyc, mon_e);
            end
        end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("pulse_missing", cyc, mon_e);
        end
    end

    int peak;
    int base;

    initial begin
        // 10 toggles into a stalled queue of depth 8
        for (int i = 0; i < 10; i++) begin
            vt[i].gap      = 5;
            vt[i].ready    = 1'b0;
            vt[i].exp_pend = (i < 8) ? i + 1 : 8;
            vt[i].exp_cnt  = i + 1;
            vt[i].exp_ovf  = (i >= 8);
        end

        reset     = 1'b1;
        t_in      = 1'b1;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        ticks(2);
        chk("rst_pulse", evt_pulse, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_count", event_count, 0);
        chk("rst_ovf", overflow, 0);

        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("warm_pulse", evt_pulse, 0);
        end
        chk("warm_pending", pending, 0);
        chk("warm_count", event_count, 0);

        // Three spaced toggles drained immediately
        evt_ready = 1'b1;
        peak = 0;
        for (int k = 0; k < 3; k++) begin
            toggle();
            for (int i = 0; i < 10; i++) begin
                tick();
                if (pending > peak) peak = pending;
            end
        end
        chk("drain_count", event_count, 3);
        chk("drain_peak", peak, 1);
        chk("drain_pending", pending, 0);

        // Stalled queue fills, saturates, overflows
        base = event_count;
        foreach (vt[i]) begin
            evt_ready = vt[i].ready;
            toggle();
            ticks(vt[i].gap);
            chk("tbl_pending", pending, vt[i].exp_pend);
            chk("tbl_count", event_count, base + vt[i].exp_cnt);
            chk("tbl_ovf", overflow, vt[i].exp_ovf);
        end

        // Drain eight events one per cycle
        evt_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("drain8_pending", pending, 8 - k);
            chk("drain8_valid", evt_valid, (k < 8) ? 1 : 0);
        end
        tick();
        chk("underflow_pending", pending, 0);
        evt_ready = 1'b0;
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Pulse coincident with handshake at pending 3
        for (int k = 0; k < 3; k++) begin
            toggle();
            ticks(5);
        end
        chk("p3_pending", pending, 3);
        chk("p3_count", event_count, 16);
        toggle();
        ticks(3);
        chk("coinc_pulse", evt_pulse, 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("coinc_pending", pending, 3);
        chk("coinc_count", event_count, 17);

        // One handshake, then build pending 5, count 20
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("hs1_pending", pending, 2);
        for (int k = 0; k < 3; k++) begin
            toggle();
            ticks(5);
        end
        chk("pre_rst_pending", pending, 5);
        chk("pre_rst_count", event_count, 20);

        // Reset mid-run with a changed input level
        reset = 1'b1;
        t_in  = ~t_in;
        tick();
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_count", event_count, 0);
        chk("mid_rst_valid", evt_valid, 0);
        tick();
        reset = 1'b0;
        ticks(10);
        chk("post_rst_count", event_count, 0);

        // Function resumes after re-learning
        toggle();
        ticks(6);
        chk("resume_count", event_count, 1);
        chk("resume_pending", pending, 1);
        ticks(4);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
